// File: rtl/jt49_dcrm_sched.sv
`timescale 1ns/1ps
// jt49_dcrm_sched: time-shares one DC-removal engine across PSG channels A, B, C each sample.
// Latency: frame_done 2 + sum over enabled channels of (k+2) cycles after cen; TMO+2 on a timeout.
// Backpressure: none; cen during a frame is dropped and recorded in sticky overrun.
module jt49_dcrm_sched #(
  parameter int TMO = 16,
  parameter int DW  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          cen,
  input  logic [2:0]    ch_en,
  input  logic [DW-1:0] din_a,
  input  logic [DW-1:0] din_b,
  input  logic [DW-1:0] din_c,
  output logic          eng_start,
  output logic [1:0]    eng_ch,
  output logic [DW-1:0] eng_din,
  input  logic          eng_done,
  input  logic [DW-1:0] eng_dout,
  output logic [DW-1:0] dout_a,
  output logic [DW-1:0] dout_b,
  output logic [DW-1:0] dout_c,
  output logic [DW+1:0] mix,
  output logic          frame_done,
  output logic          overrun,
  output logic          timeout
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_NEXT, S_COMMIT} state_t;

  state_t        state_q, state_d;
  logic [DW-1:0] cap_a_q, cap_a_d, cap_b_q, cap_b_d, cap_c_q, cap_c_d;
  logic [DW-1:0] sh_a_q, sh_a_d, sh_b_q, sh_b_d, sh_c_q, sh_c_d;
  logic [2:0]    pend_q, pend_d, en_q, en_d;
  logic [7:0]    cnt_q, cnt_d;
  logic          eng_start_q, eng_start_d;
  logic [1:0]    eng_ch_q, eng_ch_d;
  logic [DW-1:0] eng_din_q, eng_din_d;
  logic [DW-1:0] dout_a_q, dout_a_d, dout_b_q, dout_b_d, dout_c_q, dout_c_d;
  logic [DW+1:0] mix_q, mix_d;
  logic          frame_done_q, frame_done_d;
  logic          overrun_q, overrun_d, timeout_q, timeout_d;

  // Lowest pending channel goes first, giving the fixed A, B, C issue order.
  function automatic logic [1:0] lowest(input logic [2:0] m);
    if (m[0]) return 2'd0;
    if (m[1]) return 2'd1;
    return 2'd2;
  endfunction

  function automatic logic [DW-1:0] pick(input logic [1:0] ch, input logic [DW-1:0] a,
                                         input logic [DW-1:0] b, input logic [DW-1:0] c);
    case (ch)
      2'd0:    return a;
      2'd1:    return b;
      default: return c;
    endcase
  endfunction

  function automatic logic [DW+1:0] sx(input logic [DW-1:0] v);
    return {{2{v[DW-1]}}, v};
  endfunction

  // Next-state and datapath: the engine request registers are loaded on entry to ISSUE
  // so eng_start/eng_ch/eng_din are all valid together during the ISSUE cycle.
  always_comb begin
    state_d      = state_q;
    cap_a_d      = cap_a_q;
    cap_b_d      = cap_b_q;
    cap_c_d      = cap_c_q;
    sh_a_d       = sh_a_q;
    sh_b_d       = sh_b_q;
    sh_c_d       = sh_c_q;
    pend_d       = pend_q;
    en_d         = en_q;
    cnt_d        = cnt_q;
    eng_start_d  = 1'b0;
    eng_ch_d     = eng_ch_q;
    eng_din_d    = eng_din_q;
    dout_a_d     = dout_a_q;
    dout_b_d     = dout_b_q;
    dout_c_d     = dout_c_q;
    mix_d        = mix_q;
    frame_done_d = 1'b0;
    overrun_d    = overrun_q;
    timeout_d    = timeout_q;

    if (cen && (state_q != S_IDLE)) overrun_d = 1'b1;

    case (state_q)
      S_IDLE: begin
        if (cen) begin
          cap_a_d = din_a;
          cap_b_d = din_b;
          cap_c_d = din_c;
          pend_d  = ch_en;
          en_d    = ch_en;
          if (ch_en == 3'b000) begin
            state_d = S_COMMIT;
          end else begin
            state_d     = S_ISSUE;
            eng_start_d = 1'b1;
            eng_ch_d    = lowest(ch_en);
            eng_din_d   = pick(lowest(ch_en), din_a, din_b, din_c);
          end
        end
      end
      S_ISSUE: begin
        cnt_d   = 8'(TMO);
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done in the expiry cycle wins over the timeout.
        if (eng_done || (cnt_q == 8'd1)) begin
          case (eng_ch_q)
            2'd0:    sh_a_d = eng_done ? eng_dout : '0;
            2'd1:    sh_b_d = eng_done ? eng_dout : '0;
            default: sh_c_d = eng_done ? eng_dout : '0;
          endcase
          pend_d  = pend_q & ~(3'b001 << eng_ch_q);
          state_d = S_NEXT;
          if (!eng_done) timeout_d = 1'b1;
        end
        cnt_d = cnt_q - 8'd1;
      end
      S_NEXT: begin
        if (pend_q != 3'b000) begin
          state_d     = S_ISSUE;
          eng_start_d = 1'b1;
          eng_ch_d    = lowest(pend_q);
          eng_din_d   = pick(lowest(pend_q), cap_a_q, cap_b_q, cap_c_q);
        end else begin
          state_d = S_COMMIT;
        end
      end
      S_COMMIT: begin
        dout_a_d     = en_q[0] ? sh_a_q : '0;
        dout_b_d     = en_q[1] ? sh_b_q : '0;
        dout_c_d     = en_q[2] ? sh_c_q : '0;
        mix_d        = sx(dout_a_d) + sx(dout_b_d) + sx(dout_c_d);
        frame_done_d = 1'b1;
        state_d      = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and output registers; reset aborts any frame and forgets in-flight requests.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cap_a_q      <= '0;
      cap_b_q      <= '0;
      cap_c_q      <= '0;
      sh_a_q       <= '0;
      sh_b_q       <= '0;
      sh_c_q       <= '0;
      pend_q       <= '0;
      en_q         <= '0;
      cnt_q        <= '0;
      eng_start_q  <= 1'b0;
      eng_ch_q     <= '0;
      eng_din_q    <= '0;
      dout_a_q     <= '0;
      dout_b_q     <= '0;
      dout_c_q     <= '0;
      mix_q        <= '0;
      frame_done_q <= 1'b0;
      overrun_q    <= 1'b0;
      timeout_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cap_a_q      <= cap_a_d;
      cap_b_q      <= cap_b_d;
      cap_c_q      <= cap_c_d;
      sh_a_q       <= sh_a_d;
      sh_b_q       <= sh_b_d;
      sh_c_q       <= sh_c_d;
      pend_q       <= pend_d;
      en_q         <= en_d;
      cnt_q        <= cnt_d;
      eng_start_q  <= eng_start_d;
      eng_ch_q     <= eng_ch_d;
      eng_din_q    <= eng_din_d;
      dout_a_q     <= dout_a_d;
      dout_b_q     <= dout_b_d;
      dout_c_q     <= dout_c_d;
      mix_q        <= mix_d;
      frame_done_q <= frame_done_d;
      overrun_q    <= overrun_d;
      timeout_q    <= timeout_d;
    end
  end

  assign eng_start  = eng_start_q;
  assign eng_ch     = eng_ch_q;
  assign eng_din    = eng_din_q;
  assign dout_a     = dout_a_q;
  assign dout_b     = dout_b_q;
  assign dout_c     = dout_c_q;
  assign mix        = mix_q;
  assign frame_done = frame_done_q;
  assign overrun    = overrun_q;
  assign timeout    = timeout_q;

endmodule

// File: doc/jt49_dcrm_sched.md
Name: jt49_dcrm_sched

Overview:
- Time-multiplexes one shared DC-removal engine across PSG channels A, B and C.
- On each sample strobe, captures the three unsigned channel levels and issues them to the engine in order A, B, C, one at a time, using a start/done handshake.
- Collects the signed filtered results and presents them as a coherent frame, together with their signed sum.
- Sits between the channel volume stage and the output mixer.

Parameters:
- TMO, 16: maximum clk cycles to wait for eng_done after eng_start before abandoning that channel (1..255).
- DW, 8: channel sample width; the engine output is the same width, signed.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- cen  in  1  sample strobe; one-cycle pulse per audio sample
- ch_en  in  3  per-channel enable; bit0=A, bit1=B, bit2=C
- din_a  in  DW  channel A level, unsigned
- din_b  in  DW  channel B level, unsigned
- din_c  in  DW  channel C level, unsigned
- eng_start  out  1  one-cycle request to the engine
- eng_ch  out  2  engine state-bank select; 0=A, 1=B, 2=C
- eng_din  out  DW  sample issued to the engine, unsigned
- eng_done  in  1  engine result valid; one-cycle pulse
- eng_dout  in  DW  engine result, signed
- dout_a  out  DW  filtered channel A, signed
- dout_b  out  DW  filtered channel B, signed
- dout_c  out  DW  filtered channel C, signed
- mix  out  DW+2  signed sum dout_a+dout_b+dout_c
- frame_done  out  1  one-cycle pulse when the outputs update
- overrun  out  1  sticky: cen arrived while a frame was in progress
- timeout  out  1  sticky: an engine request expired

Behaviour:
- Reset (rst_n low, asynchronous): all outputs 0; FSM in IDLE; capture registers, pending mask and timeout counter cleared.
  - Asserting reset mid-frame aborts the frame immediately.
  - Engine requests left in flight are ignored; any eng_done arriving after reset release while in IDLE is dropped.
- FSM states: IDLE, ISSUE, WAIT, NEXT, COMMIT.
- IDLE:
  - On cen, latch din_a/b/c and pending = ch_en.
  - If ch_en == 0, go directly to COMMIT; otherwise go to ISSUE.
- ISSUE:
  - Select the lowest set bit of pending.
  - Drive eng_ch and eng_din from that channel's capture register, and pulse eng_start for exactly one cycle.
  - Load the counter with TMO and go to WAIT.
  - eng_ch and eng_din hold their values until the next ISSUE.
- WAIT:
  - On eng_done: store eng_dout into the shadow register for the current channel, clear its pending bit, go to NEXT.
  - Otherwise decrement the counter. On reaching 0: set timeout, store 0 in the shadow register, clear the pending bit, go to NEXT.
  - An eng_done arriving in the same cycle as counter expiry counts as done; timeout is not set.
- NEXT: if pending != 0, go to ISSUE; otherwise go to COMMIT.
- COMMIT:
  - Copy the shadows to dout_a/b/c; disabled channels output 0.
  - Register mix as the sign-extended sum of the three new values, in the same cycle.
  - Pulse frame_done and return to IDLE.
- Latency, all channels enabled and engine answering in k cycles: frame_done fires 1 + 3*(k+2) + 1 cycles after cen.
  - Outputs hold their values between frames.
- cen outside IDLE: sample discarded, overrun set. Sticky flags clear only on reset.
- ch_en is sampled only at capture; changes mid-frame take effect at the next frame.
- eng_done outside WAIT is ignored.
- mix width: DW+2 bits cover three DW-bit signed terms without overflow. Range at DW=8: -384..381.
- Arithmetic: no saturation anywhere; engine values pass through unmodified.

Test Plan:
- Basic frame: ch_en=7, din a/b/c=0x40/0x80/0xC0; engine model returns din-0x60 after 3 cycles.
  - eng_ch sequence is 0, 1, 2.
  - dout = 0xE0/0x20/0x60; mix = 0x060.
  - frame_done exactly 17 cycles after cen.
- Masked channels: ch_en=3'b010, din_b=0x90, engine returns 0x30.
  - Only one eng_start, with eng_ch=1.
  - dout_a = dout_c = 0; dout_b = 0x30; mix = 0x030.
- Timeout: TMO=16, engine never answers channel B.
  - timeout=1; dout_b=0.
  - A and C carry normal results; frame_done still occurs.
  - Done-on-expiry cycle: no timeout flag.
- Overrun: second cen issued 5 cycles after the first.
  - overrun=1; captured data unchanged; only one frame_done.
  - Next cen after COMMIT is processed normally.
- Mix extremes: engine returns 0x80 for all three → mix = -384 (0x280). Returns 0x7F for all three → mix = 381 (0x17D).
- Reset mid-WAIT: drop rst_n during channel B WAIT.
  - All outputs are 0 immediately, asynchronously.
  - A late eng_done after release is ignored; the next cen yields a clean frame.
